// File: rtl/ras_checkpoint_unit_if.sv
// Checkpoint-unit bus: branch allocation, resolution/flush and RAS repair signals.
// The master modport drives allocations and resolutions; the slave modport is the unit itself.
interface ras_checkpoint_unit_if #(
  parameter int RAS_ADDRESS  = 3,
  parameter int XLEN         = 32,
  parameter int CKPT_ADDRESS = 3
);
  logic                    ckpt_alloc;
  logic [RAS_ADDRESS-1:0]  sp_snap;
  logic [2*XLEN-1:0]       ras_snap;
  logic [CKPT_ADDRESS-1:0] ckpt_tag;
  logic                    ckpt_full;
  logic [CKPT_ADDRESS:0]   ckpt_count;
  logic                    resolve_valid;
  logic [CKPT_ADDRESS-1:0] resolve_tag;
  logic                    resolve_mispredict;
  logic                    flush;
  logic                    restore_valid;
  logic [RAS_ADDRESS-1:0]  restore_sp;
  logic [2*XLEN-1:0]       restore_top;

  modport master (
    output ckpt_alloc, sp_snap, ras_snap, resolve_valid, resolve_tag,
           resolve_mispredict, flush,
    input  ckpt_tag, ckpt_full, ckpt_count, restore_valid, restore_sp, restore_top
  );

  modport slave (
    input  ckpt_alloc, sp_snap, ras_snap, resolve_valid, resolve_tag,
           resolve_mispredict, flush,
    output ckpt_tag, ckpt_full, ckpt_count, restore_valid, restore_sp, restore_top
  );
endinterface

// File: rtl/ras_checkpoint_unit.sv
// In-order RAS checkpoint queue: one snapshot per in-flight branch, retired in order,
// replayed to the RAS repair port one cycle after an accepted mispredict.
module ras_checkpoint_unit #(
  parameter int RAS_ADDRESS  = 3,
  parameter int XLEN         = 32,
  parameter int CKPT_ADDRESS = 3
) (
  input  logic                 CLK,
  input  logic                 reset,
  ras_checkpoint_unit_if.slave bus
);
  localparam int DEPTH = 1 << CKPT_ADDRESS;

  typedef logic [CKPT_ADDRESS:0]   ptr_t;
  typedef logic [CKPT_ADDRESS-1:0] idx_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t PTR_FULL = ptr_t'(DEPTH);

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [DEPTH-1:0]       resolved_q, resolved_d;
  ptr_t                   head_q, head_d;
  ptr_t                   tail_q, tail_d;
  logic [RAS_ADDRESS-1:0] sp_q  [DEPTH];
  logic [2*XLEN-1:0]      top_q [DEPTH];
  logic                   restore_valid_q;
  logic [RAS_ADDRESS-1:0] restore_sp_q;
  logic [2*XLEN-1:0]      restore_top_q;

  ptr_t count;
  logic full;
  idx_t head_idx;
  idx_t tail_idx;
  idx_t mis_off;
  logic retire;
  logic res_acc;
  logic mis_acc;
  logic alloc_acc;

  assign count     = tail_q - head_q;
  assign full      = (count == PTR_FULL);
  assign head_idx  = head_q[CKPT_ADDRESS-1:0];
  assign tail_idx  = tail_q[CKPT_ADDRESS-1:0];
  assign mis_off   = bus.resolve_tag - head_idx;
  assign retire    = valid_q[head_idx] && resolved_q[head_idx];
  assign res_acc   = bus.resolve_valid && !bus.resolve_mispredict && valid_q[bus.resolve_tag];
  assign mis_acc   = bus.resolve_valid && bus.resolve_mispredict && valid_q[bus.resolve_tag]
                     && !bus.flush;
  assign alloc_acc = bus.ckpt_alloc && !full && !bus.flush && !mis_acc;

  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (bus.flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (retire) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + PTR_ONE;
      end
      if (res_acc) begin
        resolved_d[bus.resolve_tag] = 1'b1;
      end
      if (mis_acc) begin
        resolved_d[bus.resolve_tag] = 1'b1;
        // Age is the distance from head; anything farther than the mispredicted tag is wrong-path.
        for (int i = 0; i < DEPTH; i++) begin
          if (idx_t'(idx_t'(i) - head_idx) > mis_off) begin
            valid_d[i] = 1'b0;
          end
        end
        tail_d = head_q + ptr_t'(mis_off) + PTR_ONE;
      end
      if (alloc_acc) begin
        valid_d[tail_idx]    = 1'b1;
        resolved_d[tail_idx] = 1'b0;
        tail_d               = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      valid_q         <= '0;
      resolved_q      <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      restore_valid_q <= 1'b0;
      restore_sp_q    <= '0;
      restore_top_q   <= '0;
    end else begin
      valid_q         <= valid_d;
      resolved_q      <= resolved_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      restore_valid_q <= mis_acc;
      if (mis_acc) begin
        restore_sp_q  <= sp_q[bus.resolve_tag];
        restore_top_q <= top_q[bus.resolve_tag];
      end
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (alloc_acc) begin
      sp_q[tail_idx]  <= bus.sp_snap;
      top_q[tail_idx] <= bus.ras_snap;
    end
  end

  assign bus.ckpt_tag      = tail_idx;
  assign bus.ckpt_full     = full;
  assign bus.ckpt_count    = count;
  assign bus.restore_valid = restore_valid_q;
  assign bus.restore_sp    = restore_sp_q;
  assign bus.restore_top   = restore_top_q;
endmodule

// File: tb/tb_ras_checkpoint_unit.sv
// Directed scenarios plus a random soak, checked against an ordered-queue model of the checkpoints.
module tb_ras_checkpoint_unit;
  logic CLK;
  logic reset;
  int   n_checks;
  int   n_fail;

  ras_checkpoint_unit_if #(.RAS_ADDRESS(3), .XLEN(32), .CKPT_ADDRESS(3)) bus ();

  ras_checkpoint_unit #(.RAS_ADDRESS(3), .XLEN(32), .CKPT_ADDRESS(3)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          tag;
    logic [2:0]  sp;
    logic [63:0] top;
    bit          res;
  } ent_t;

  ent_t        mq[$];
  int          mt;
  logic        exp_rv;
  logic [2:0]  exp_rsp;
  logic [63:0] exp_rtop;

  task automatic drive(input logic al, input logic [2:0] sp, input logic [63:0] top,
                       input logic rv, input logic [2:0] tag, input logic mis, input logic fl);
    bus.ckpt_alloc         = al;
    bus.sp_snap            = sp;
    bus.ras_snap           = top;
    bus.resolve_valid      = rv;
    bus.resolve_tag        = tag;
    bus.resolve_mispredict = mis;
    bus.flush              = fl;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // Reference behaviour: checkpoints as an age-ordered list of tagged snapshots.
  task automatic model_update();
    int  pos;
    int  size0;
    bit  ret;
    bit  mis;
    ent_t e;
    if (reset) begin
      mq.delete(); mt = 0; exp_rv = 0; exp_rsp = '0; exp_rtop = '0;
    end else if (bus.flush) begin
      mq.delete(); mt = 0; exp_rv = 0;
    end else begin
      size0 = mq.size();
      ret   = (size0 > 0) && mq[0].res;
      mis   = 0;
      pos   = -1;
      exp_rv = 0;
      for (int i = 0; i < mq.size(); i++) if (mq[i].tag == int'(bus.resolve_tag)) pos = i;
      if (bus.resolve_valid && pos >= 0) begin
        mq[pos].res = 1;
        if (bus.resolve_mispredict) begin
          mis = 1; exp_rv = 1; exp_rsp = mq[pos].sp; exp_rtop = mq[pos].top;
          while (mq.size() > pos + 1) void'(mq.pop_back());
          mt = (int'(bus.resolve_tag) + 1) % 8;
        end
      end
      if (ret) void'(mq.pop_front());
      if (bus.ckpt_alloc && !mis && size0 < 8) begin
        e.tag = mt; e.sp = bus.sp_snap; e.top = bus.ras_snap; e.res = 0;
        mq.push_back(e);
        mt = (mt + 1) % 8;
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 3'd5, 64'hDEAD, 1'b1, 3'd0, 1'b1, 1'b0);
    step();
    step();
    reset = 1'b0;
    idle();
    n_checks++; if (bus.ckpt_tag !== 3'd0) begin n_fail++; $display("FAIL reset_tag got %0d want 0", bus.ckpt_tag); end
    n_checks++; if (bus.ckpt_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.ckpt_count); end
    n_checks++; if (bus.ckpt_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", bus.ckpt_full); end
    n_checks++; if (bus.restore_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %0b want 0", bus.restore_valid); end
    n_checks++; if (bus.restore_sp !== 3'd0) begin n_fail++; $display("FAIL reset_rsp got %0d want 0", bus.restore_sp); end
    n_checks++; if (bus.restore_top !== 64'd0) begin n_fail++; $display("FAIL reset_rtop got %0h want 0", bus.restore_top); end
  endtask

  task automatic test_alloc3();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.ckpt_tag !== 3'(i)) begin n_fail++; $display("FAIL alloc3_tag got %0d want %0d", bus.ckpt_tag, i); end
      drive(1'b1, 3'(i + 1), {$urandom, $urandom}, 1'b0, 3'd0, 1'b0, 1'b0);
      step();
    end
    idle();
    n_checks++; if (bus.ckpt_tag !== 3'd3) begin n_fail++; $display("FAIL alloc3_tag_end got %0d want 3", bus.ckpt_tag); end
    n_checks++; if (bus.ckpt_count !== 4'd3) begin n_fail++; $display("FAIL alloc3_count got %0d want 3", bus.ckpt_count); end
    n_checks++; if (bus.restore_valid !== 1'b0) begin n_fail++; $display("FAIL alloc3_rv got %0b want 0", bus.restore_valid); end
  endtask

  task automatic test_full();
    for (int i = 3; i < 8; i++) begin
      drive(1'b1, 3'(i + 1), 64'(i), 1'b0, 3'd0, 1'b0, 1'b0);
      step();
    end
    n_checks++; if (bus.ckpt_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %0b want 1", bus.ckpt_full); end
    drive(1'b1, 3'd7, 64'hBAD, 1'b0, 3'd0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.ckpt_count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", bus.ckpt_count); end
    n_checks++; if (bus.ckpt_full !== 1'b1) begin n_fail++; $display("FAIL full_flag2 got %0b want 1", bus.ckpt_full); end
    drive(1'b0, 3'd0, 64'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    step();
    idle();
    n_checks++; if (bus.restore_sp !== 3'd1) begin n_fail++; $display("FAIL full_tag0_payload got %0d want 1", bus.restore_sp); end
    n_checks++; if (bus.ckpt_count !== 4'd1) begin n_fail++; $display("FAIL full_mis_count got %0d want 1", bus.ckpt_count); end
    drive(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    step();
    idle();
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i + 1), 64'hA + 64'(i), 1'b0, 3'd0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 3'd0, 64'd0, 1'b1, 3'd2, 1'b1, 1'b0);
    step();
    idle();
    n_checks++; if (bus.restore_valid !== 1'b1) begin n_fail++; $display("FAIL mis_rv got %0b want 1", bus.restore_valid); end
    n_checks++; if (bus.restore_sp !== 3'd3) begin n_fail++; $display("FAIL mis_rsp got %0d want 3", bus.restore_sp); end
    n_checks++; if (bus.restore_top !== 64'hC) begin n_fail++; $display("FAIL mis_rtop got %0h want c", bus.restore_top); end
    n_checks++; if (bus.ckpt_count !== 4'd3) begin n_fail++; $display("FAIL mis_count got %0d want 3", bus.ckpt_count); end
    n_checks++; if (bus.ckpt_tag !== 3'd3) begin n_fail++; $display("FAIL mis_tag got %0d want 3", bus.ckpt_tag); end
    step();
    n_checks++; if (bus.restore_valid !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_len got %0b want 0", bus.restore_valid); end
  endtask

  task automatic test_in_order_retire();
    int want[6] = '{3, 3, 3, 2, 1, 0};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b0, 3'd0, 64'd0, 1'b1, 3'(2 - i), 1'b0, 1'b0);
      else idle();
      step();
      n_checks++; if (bus.ckpt_count !== 4'(want[i])) begin n_fail++; $display("FAIL retire_count[%0d] got %0d want %0d", i, bus.ckpt_count, want[i]); end
    end
    idle();
  endtask

  task automatic test_wrap();
    drive(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'(i), 64'(i), 1'b0, 3'd0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1'b0, 3'd0, 64'd0, 1'b1, 3'(i), 1'b0, 1'b0);
      else idle();
      step();
    end
    n_checks++; if (bus.ckpt_count !== 4'd0) begin n_fail++; $display("FAIL wrap_drain got %0d want 0", bus.ckpt_count); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.ckpt_tag !== 3'((6 + i) % 8)) begin n_fail++; $display("FAIL wrap_tag[%0d] got %0d want %0d", i, bus.ckpt_tag, (6 + i) % 8); end
      drive(1'b1, 3'((i + 4) % 8), 64'h70 + 64'(i), 1'b0, 3'd0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 3'd0, 64'd0, 1'b1, 3'd7, 1'b1, 1'b0);
    step();
    idle();
    n_checks++; if (bus.restore_sp !== 3'd5) begin n_fail++; $display("FAIL wrap_rsp got %0d want 5", bus.restore_sp); end
    n_checks++; if (bus.restore_top !== 64'h71) begin n_fail++; $display("FAIL wrap_rtop got %0h want 71", bus.restore_top); end
    n_checks++; if (bus.ckpt_tag !== 3'd0) begin n_fail++; $display("FAIL wrap_tag_after got %0d want 0", bus.ckpt_tag); end
  endtask

  task automatic test_conflict();
    drive(1'b1, 3'd3, 64'h33, 1'b1, 3'd6, 1'b1, 1'b0);
    step();
    n_checks++; if (bus.ckpt_count !== 4'd1) begin n_fail++; $display("FAIL conflict_count got %0d want 1", bus.ckpt_count); end
    n_checks++; if (bus.ckpt_tag !== 3'd7) begin n_fail++; $display("FAIL conflict_tag got %0d want 7", bus.ckpt_tag); end
    n_checks++; if (bus.restore_sp !== 3'd4) begin n_fail++; $display("FAIL conflict_rsp got %0d want 4", bus.restore_sp); end
    drive(1'b1, 3'd1, 64'h11, 1'b1, 3'd6, 1'b1, 1'b1);
    step();
    idle();
    n_checks++; if (bus.ckpt_count !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", bus.ckpt_count); end
    n_checks++; if (bus.ckpt_tag !== 3'd0) begin n_fail++; $display("FAIL flush_tag got %0d want 0", bus.ckpt_tag); end
    n_checks++; if (bus.restore_valid !== 1'b0) begin n_fail++; $display("FAIL flush_rv got %0b want 0", bus.restore_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i + 5), 64'h50 + 64'(i), 1'b0, 3'd0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 3'd0, 64'd0, 1'b1, 3'd2, 1'b1, 1'b0);
    step();
    n_checks++; if (bus.restore_valid !== 1'b1 || bus.restore_sp !== 3'd7) begin n_fail++; $display("FAIL b2b_first got rv=%0b sp=%0d want rv=1 sp=7", bus.restore_valid, bus.restore_sp); end
    drive(1'b0, 3'd0, 64'd0, 1'b1, 3'd1, 1'b1, 1'b0);
    step();
    n_checks++; if (bus.restore_valid !== 1'b1 || bus.restore_sp !== 3'd6) begin n_fail++; $display("FAIL b2b_second got rv=%0b sp=%0d want rv=1 sp=6", bus.restore_valid, bus.restore_sp); end
    drive(1'b0, 3'd0, 64'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    n_checks++; if (bus.restore_valid !== 1'b0 || bus.restore_sp !== 3'd0 || bus.restore_top !== 64'd0) begin n_fail++; $display("FAIL reset_mid_restore got rv=%0b sp=%0d top=%0h want all 0", bus.restore_valid, bus.restore_sp, bus.restore_top); end
  endtask

  task automatic test_random();
    logic [2:0] tag;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) tag = 3'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else tag = 3'($urandom_range(0, 7));
      drive($urandom_range(0, 9) < 6, 3'($urandom), {$urandom, $urandom},
            $urandom_range(0, 9) < 4, tag, $urandom_range(0, 9) < 2, $urandom_range(0, 99) < 2);
      step();
      n_checks++; if (bus.ckpt_tag !== 3'(mt)) begin n_fail++; $display("FAIL rnd_tag cyc %0d got %0d want %0d", c, bus.ckpt_tag, mt); end
      n_checks++; if (bus.ckpt_count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, bus.ckpt_count, mq.size()); end
      n_checks++; if (bus.ckpt_full !== (mq.size() == 8)) begin n_fail++; $display("FAIL rnd_full cyc %0d got %0b want %0b", c, bus.ckpt_full, mq.size() == 8); end
      n_checks++; if (bus.restore_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_rv cyc %0d got %0b want %0b", c, bus.restore_valid, exp_rv); end
      n_checks++; if (bus.restore_sp !== exp_rsp) begin n_fail++; $display("FAIL rnd_rsp cyc %0d got %0d want %0d", c, bus.restore_sp, exp_rsp); end
      n_checks++; if (bus.restore_top !== exp_rtop) begin n_fail++; $display("FAIL rnd_rtop cyc %0d got %0h want %0h", c, bus.restore_top, exp_rtop); end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mt       = 0;
    exp_rv   = 0;
    exp_rsp  = '0;
    exp_rtop = '0;
    reset    = 1'b1;
    idle();
    test_reset();
    test_alloc3();
    test_full();
    test_mispredict();
    test_in_order_retire();
    test_wrap();
    test_conflict();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
